mem_port_arbiter: RTL and testbench

//  Shares one single-ported memory between instruction fetch (IF) and load/store (D) requesters.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_pick.sv | 37 +++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_REQ  = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner select between fetch and data requesters.
// MEM_PORT_ARB_RR_EN: round-robin on contention (requester not served last wins);
// otherwise fixed data priority and last_owner is ignored.
module mem_port_arb_pick
   import mem_port_arbiter_pkg::*;
(
   input  logic       if_req,
   input  logic       d_req,
   input  arb_owner_t last_owner,
   output logic       valid,
   output arb_owner_t winner
);

   // winner select; only meaningful while valid is high
   always_comb begin
      valid  = if_req | d_req;
      winner = OWN_IF;
`ifdef MEM_PORT_ARB_RR_EN
      if (if_req && d_req) begin
         winner = (last_owner == OWN_D) ? OWN_IF : OWN_D;
      end else if (d_req) begin
         winner = OWN_D;
      end
`else
      if (d_req) begin
         winner = OWN_D;
      end
`endif
   end

`ifndef MEM_PORT_ARB_RR_EN
   // fixed priority has no use for the history input
   logic unused_last_owner;
   assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// One transaction outstanding; the granted request is latched and replayed to memory.
// MEM_PORT_ARB_RR_EN: round-robin arbitration on contention (default: data priority).
//
// state    | meaning
// ARB_IDLE | no transaction; grant a pending request and latch it
// ARB_REQ  | mem_req held with latched fields until mem_gnt
// ARB_RESP | waiting for mem_rvalid; forward it to the owner
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            if_req,
   input  logic [AW-1:0]   if_addr,
   output logic            if_gnt,
   output logic            if_rvalid,
   output logic [DW-1:0]   if_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_be,
   output logic            d_gnt,
   output logic            d_rvalid,
   output logic [DW-1:0]   d_rdata,
   output logic            mem_req,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_be,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [DW-1:0]   mem_rdata,
   output logic            busy
);

   arb_state_t      state, state_nxt;
   arb_owner_t      owner_q;
   arb_owner_t      last_owner;
   arb_owner_t      winner;
   logic            pick_valid;
   logic            grant;
   logic            we_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic [DW/8-1:0] be_q;

   mem_port_arb_pick u_pick (
      .if_req     (if_req),
      .d_req      (d_req),
      .last_owner (last_owner),
      .valid      (pick_valid),
      .winner     (winner)
   );

   // state register plus latched copy of the granted request
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ARB_IDLE;
         owner_q <= OWN_IF;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            owner_q <= winner;
            if (winner == OWN_D) begin
               we_q    <= d_we;
               addr_q  <= d_addr;
               wdata_q <= d_wdata;
               be_q    <= d_be;
            end else begin
               we_q    <= 1'b0;
               addr_q  <= if_addr;
               wdata_q <= '0;
               be_q    <= '1;
            end
         end
      end
   end

`ifdef MEM_PORT_ARB_RR_EN
   // history for round-robin; starts as D so the first contended grant goes to fetch
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_owner <= OWN_D;
      end else if (grant) begin
         last_owner <= winner;
      end
   end
`else
   assign last_owner = OWN_D;
`endif

   // next state and handshake pulses; grants are held off while reset is asserted
   always_comb begin
      state_nxt = state;
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      if_rvalid = 1'b0;
      d_rvalid  = 1'b0;
      mem_req   = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (pick_valid && rst_n) begin
               if_gnt    = (winner == OWN_IF);
               d_gnt     = (winner == OWN_D);
               state_nxt = ARB_REQ;
            end
         end
         ARB_REQ: begin
            mem_req = 1'b1;
            if (mem_gnt) begin
               state_nxt = ARB_RESP;
            end
         end
         ARB_RESP: begin
            if (mem_rvalid) begin
               if_rvalid = (owner_q == OWN_IF);
               d_rvalid  = (owner_q == OWN_D);
               state_nxt = ARB_IDLE;
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   assign grant     = if_gnt | d_gnt;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_be    = be_q;
   assign busy      = (state != ARB_IDLE);

   // read data only visible in the owner's response cycle; stores return zero
   assign if_rdata = if_rvalid ? mem_rdata : '0;
   assign d_rdata  = (d_rvalid && !we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, multi-cycle corner
// sequences and randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, if_gnt, if_rvalid;
   logic [31:0] if_addr, if_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_be;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   logic [31:0] dev_mem [256];
   logic [31:0] ref_mem [256];
   logic        model_last;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(32), .DW(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_gnt     (if_gnt),
      .if_rvalid  (if_rvalid),
      .if_rdata   (if_rdata),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_be       (d_be),
      .d_gnt      (d_gnt),
      .d_rvalid   (d_rvalid),
      .d_rdata    (d_rdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_be     (mem_be),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .busy       (busy)
   );

   typedef struct {
      logic        is_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        exp_we;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // 1 = data requester wins
   function automatic logic model_pick(input logic pi, input logic pd, input logic last_d);
      if (pi && pd) begin
`ifdef MEM_PORT_ARB_RR_EN
         return !last_d;
`else
         return 1'b1;
`endif
      end
      return pd;
   endfunction

   function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] nw,
                                            input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
      end
      return r;
   endfunction

   // Runs one transaction whose request is already driven; the bench acts as the memory.
   task automatic txn(input logic exp_d, input logic [31:0] ea, input logic ewe,
                      input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd,
                      input int gw, input int rw, input bit stray);
      logic [31:0] resp;
      logic [7:0]  idx;
      resp = 32'd0;
      @(negedge clk);
      chk("if_gnt", {31'd0, if_gnt}, {31'd0, ~exp_d});
      chk("d_gnt", {31'd0, d_gnt}, {31'd0, exp_d});
      @(posedge clk); #1;
      if (exp_d) d_req = 1'b0; else if_req = 1'b0;
      for (int i = 0; i <= gw; i++) begin
         mem_gnt    = (i == gw);
         mem_rvalid = stray;
         mem_rdata  = stray ? $urandom : 32'd0;
         @(negedge clk);
         chk("mem_req", {31'd0, mem_req}, 32'd1);
         chk("busy_req", {31'd0, busy}, 32'd1);
         chk("mem_addr", mem_addr, ea);
         chk("mem_we", {31'd0, mem_we}, {31'd0, ewe});
         chk("mem_be", {28'd0, mem_be}, {28'd0, ebe});
         chk("mem_wdata", mem_wdata, ewd);
         chk("no_gnt_req", {30'd0, if_gnt, d_gnt}, 32'd0);
         chk("no_rvalid_req", {30'd0, if_rvalid, d_rvalid}, 32'd0);
         if (i == gw) begin
            idx = mem_addr[9:2];
            if (mem_we) begin
               dev_mem[idx] = merge_be(dev_mem[idx], mem_wdata, mem_be);
               resp = 32'hBAD0_0000 ^ $urandom;
            end else begin
               resp = dev_mem[idx];
            end
         end
         @(posedge clk); #1;
      end
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'd0;
      for (int i = 0; i < rw; i++) begin
         @(negedge clk);
         chk("no_rvalid_wait", {30'd0, if_rvalid, d_rvalid}, 32'd0);
         chk("busy_resp", {31'd0, busy}, 32'd1);
         chk("mem_req_resp", {31'd0, mem_req}, 32'd0);
         @(posedge clk); #1;
      end
      mem_rvalid = 1'b1;
      mem_rdata  = resp;
      @(negedge clk);
      chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, ~exp_d});
      chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, exp_d});
      chk("owner_rdata", exp_d ? d_rdata : if_rdata, erd);
      chk("other_rdata", exp_d ? if_rdata : d_rdata, 32'd0);
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'd0;
      model_last = exp_d;
   endtask

   task automatic drive_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be);
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
   endtask

   // contention helper: fetch of 0x40 or load of 0x100
   task automatic issue(input logic w);
      if (w) txn(1'b1, 32'h100, 1'b0, 4'hF, 32'd0, 32'h1111_BEEF, 0, 0, 1'b0);
      else   txn(1'b0, 32'h40, 1'b0, 4'hF, 32'd0, 32'h0010_0093, 0, 0, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        w;
      logic        p_if, p_d, pd_we;
      logic [31:0] pi_addr, pd_addr, pd_wdata, r, erd;
      logic [3:0]  pd_be;
      int          gw, rw;
      bit          stray;

      rst_n = 1'b0; if_req = 1'b0; if_addr = 32'd0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; d_be = 4'd0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
      model_last = 1'b1;
      for (int i = 0; i < 256; i++) begin dev_mem[i] = 32'd0; ref_mem[i] = 32'd0; end
      dev_mem[16]  = 32'h0010_0093;
      dev_mem[64]  = 32'h1111_2222;
      dev_mem[255] = 32'hA5A5_5A5A;

      vecs[0] = '{1'b0, 1'b0, 32'h40,  32'd0,        4'h0, 1'b0, 4'hF, 32'd0,        32'h0010_0093};
      vecs[1] = '{1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'h3, 1'b1, 4'h3, 32'hDEAD_BEEF, 32'd0};
      vecs[2] = '{1'b1, 1'b0, 32'h100, 32'd0,        4'hF, 1'b0, 4'hF, 32'd0,        32'h1111_BEEF};
      vecs[3] = '{1'b0, 1'b0, 32'h3FC, 32'd0,        4'h0, 1'b0, 4'hF, 32'd0,        32'hA5A5_5A5A};
      vecs[4] = '{1'b1, 1'b1, 32'h3FC, 32'h1234_5678, 4'hC, 1'b1, 4'hC, 32'h1234_5678, 32'd0};
      vecs[5] = '{1'b1, 1'b0, 32'h3FC, 32'h0000_0055, 4'h0, 1'b0, 4'h0, 32'h0000_0055, 32'h1234_5A5A};
      vecs[6] = '{1'b0, 1'b0, 32'h0,   32'd0,        4'h0, 1'b0, 4'hF, 32'd0,        32'd0};

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
      chk("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rdata", if_rdata | d_rdata, 32'd0);
      chk("rst_fields", mem_addr | mem_wdata | {27'd0, mem_we, mem_be}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // directed table, zero-wait memory
      foreach (vecs[k]) begin
         if (vecs[k].is_d) drive_d(vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].be);
         else begin if_req = 1'b1; if_addr = vecs[k].addr; end
         txn(vecs[k].is_d, vecs[k].addr, vecs[k].exp_we, vecs[k].exp_be, vecs[k].exp_wdata,
             vecs[k].exp_rdata, 0, 0, 1'b0);
      end

      // wait states on both handshakes
      drive_d(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF);
      txn(1'b1, 32'h20, 1'b1, 4'hF, 32'hCAFE_F00D, 32'd0, 3, 2, 1'b0);

      // stray mem_rvalid in IDLE, then during REQ
      mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
      @(negedge clk);
      chk("stray_idle_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
      chk("stray_idle_busy", {31'd0, busy}, 32'd0);
      chk("stray_idle_rdata", if_rdata | d_rdata, 32'd0);
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_rdata = 32'd0;
      if_req = 1'b1; if_addr = 32'h40;
      txn(1'b0, 32'h40, 1'b0, 4'hF, 32'd0, 32'h0010_0093, 2, 0, 1'b1);

      // reset during RESP abandons the transaction
      if_req = 1'b1; if_addr = 32'h40;
      @(negedge clk);
      chk("rstresp_gnt", {31'd0, if_gnt}, 32'd1);
      @(posedge clk); #1;
      if_req = 1'b0; mem_gnt = 1'b1;
      @(negedge clk);
      chk("rstresp_mem_req", {31'd0, mem_req}, 32'd1);
      @(posedge clk); #1;
      mem_gnt = 1'b0; rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1; model_last = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
      @(negedge clk);
      chk("rstresp_busy", {31'd0, busy}, 32'd0);
      chk("rstresp_mem_req0", {31'd0, mem_req}, 32'd0);
      chk("rstresp_late_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
      chk("rstresp_rdata", if_rdata | d_rdata, 32'd0);
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_rdata = 32'd0;

      // contention: both requesting for two grants, then drain
      if_req = 1'b1; if_addr = 32'h40;
      drive_d(1'b0, 32'h100, 32'd0, 4'hF);
      w = model_pick(1'b1, 1'b1, model_last);
      issue(w);
      if (w) drive_d(1'b0, 32'h100, 32'd0, 4'hF); else begin if_req = 1'b1; if_addr = 32'h40; end
      w = model_pick(1'b1, 1'b1, model_last);
      issue(w);
      issue(~w);

      // randomized traffic against the reference memory
      for (int i = 0; i < 256; i++) begin
         r = $urandom; dev_mem[i] = r; ref_mem[i] = r;
      end
      p_if = 1'b0; p_d = 1'b0; pd_we = 1'b0;
      pi_addr = 32'd0; pd_addr = 32'd0; pd_wdata = 32'd0; pd_be = 4'd0;
      for (int n = 0; n < 120; n++) begin
         if (!p_if && $urandom_range(0, 1) == 1) begin
            p_if = 1'b1; r = $urandom_range(0, 255); pi_addr = {22'd0, r[7:0], 2'b00};
         end
         if (!p_d && $urandom_range(0, 1) == 1) begin
            p_d = 1'b1; r = $urandom; pd_we = r[0]; pd_be = r[7:4];
            r = $urandom_range(0, 255); pd_addr = {22'd0, r[7:0], 2'b00}; pd_wdata = $urandom;
         end
         if (!p_if && !p_d) begin
            p_if = 1'b1; r = $urandom_range(0, 255); pi_addr = {22'd0, r[7:0], 2'b00};
         end
         if_req = p_if; if_addr = pi_addr;
         d_req = p_d; d_we = pd_we; d_addr = pd_addr; d_wdata = pd_wdata; d_be = pd_be;
         gw = $urandom_range(0, 2);
         rw = $urandom_range(0, 2);
         stray = ($urandom_range(0, 3) == 0);
         w = model_pick(p_if, p_d, model_last);
         if (w) begin
            erd = pd_we ? 32'd0 : ref_mem[pd_addr[9:2]];
            txn(1'b1, pd_addr, pd_we, pd_be, pd_wdata, erd, gw, rw, stray);
            if (pd_we) ref_mem[pd_addr[9:2]] = merge_be(ref_mem[pd_addr[9:2]], pd_wdata, pd_be);
            p_d = 1'b0;
         end else begin
            erd = ref_mem[pi_addr[9:2]];
            txn(1'b0, pi_addr, 1'b0, 4'hF, 32'd0, erd, gw, rw, stray);
            p_if = 1'b0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
